arith_op_sequencer: RTL and testbench
=====================================

Name: arith_op_sequencer

Overview:
Sequential initiator for the combinational 4-bit add/sub arithmetic unit, which computes d = a + y + cin, where y is selected by s from {b, ~b, 0, 1}.
- Accepts operation requests over a valid/ready handshake and drives the unit's operand inputs from registers.
- Waits a programmable settle time covering the gate-delay ripple, then captures d/cout.
- Returns the result with status flags and a self-check mismatch bit over a second valid/ready handshake.

Parameters:
WIDTH, 4, operand/result width; must match the arithmetic unit.
SETTLE_CYCLES, 3, clock cycles between operand drive and capture; legal range is 1 or more.

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_a  in  WIDTH  operand a
req_b  in  WIDTH  operand b
req_op  in  2  operation; drives the unit's s input
req_cin  in  1  carry-in
au_a  out  WIDTH  registered operand a to the unit
au_b  out  WIDTH  registered operand b to the unit
au_s  out  2  registered select to the unit
au_cin  out  1  registered carry-in to the unit
au_d  in  WIDTH  unit sum
au_cout  in  1  unit carry-out
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_d  out  WIDTH  captured sum
rsp_cout  out  1  captured carry-out
rsp_zero  out  1  rsp_d == 0
rsp_ovf  out  1  two's-complement overflow
rsp_mismatch  out  1  captured {cout,d} differs from the internal reference
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; au_*=0; rsp_* all 0 (including rsp_valid); req_ready=1 in the first cycle after reset deasserts; busy=0.
- Op encoding, which gives the operand y:
  - 00 ADD: y=b
  - 01 SUB: y=~b; with cin=1 the result is a-b
  - 10 PASS: y=0
  - 11 INC: y=all ones, i.e. adds -1 mod 2^WIDTH plus cin
- States: IDLE, SETTLE, RESP.
- req_ready is 1 only in IDLE; it is combinational from state.
- IDLE: on req_valid&&req_ready at edge T:
  - au_a/au_b/au_s/au_cin <= req_*;
  - settle counter <= SETTLE_CYCLES-1;
  - go to SETTLE.
- SETTLE: counter decrements each edge. At the edge where the counter reads 0:
  - capture rsp_d<=au_d and rsp_cout<=au_cout;
  - compute rsp_zero, rsp_ovf and rsp_mismatch from the captured values;
  - rsp_valid<=1; go to RESP.
  - First rsp_valid=1 cycle follows edge T+SETTLE_CYCLES.
- RESP: all rsp_* are held stable while rsp_valid&&!rsp_ready. On rsp_valid&&rsp_ready: rsp_valid<=0 and go to IDLE.
  - Minimum request-to-request spacing is SETTLE_CYCLES+2 cycles.
- au_* outputs change only on request acceptance; they hold their values through SETTLE, RESP and IDLE.
- rsp_ovf = (au_a[MSB]==y[MSB]) && (rsp_d[MSB]!=au_a[MSB]), with y the selected operand.
- Reference model: {cout,d} = au_a + y + au_cin, computed at WIDTH+1 bits and compared with {au_cout,au_d} at capture.
  - rsp_mismatch asserts when they differ; the captured unit values are still reported unmodified.
- Wrap-around: sums are taken mod 2^WIDTH; carry-out is reported only through rsp_cout.
- Simultaneous events:
  - req_valid outside IDLE is ignored, with no queuing.
  - rsp_ready outside RESP has no effect.
- Reset mid-operation, in any state: next state is IDLE, in-flight result is discarded, rsp_valid=0, au_*=0.

Decomposition:
- Package arith_seq_pkg:
  - op constants OP_ADD=2'b00, OP_SUB=2'b01, OP_PASS=2'b10, OP_INC=2'b11;
  - state enum typedef {IDLE, SETTLE, RESP};
  - default WIDTH and SETTLE_CYCLES.
- One sub-module, arith_ref_model: combinational; computes y, the expected {cout,d} and overflow from a, b, op, cin. The bench reuses it as its scoreboard.

Test Plan:
1. ADD: a=3, b=3, op=00, cin=0, real unit attached. Response: rsp_d=6, cout=0, zero=0, ovf=0, mismatch=0; rsp_valid rises exactly SETTLE_CYCLES edges after acceptance.
2. SUB: a=5, b=3, op=01, cin=1 -> rsp_d=2, cout=1. Then a=3, b=5, op=01, cin=1 -> rsp_d=14, cout=0.
3. Wrap and flags:
   - a=15, b=1, op=00 -> rsp_d=0, cout=1, zero=1, ovf=0.
   - a=7, b=1, op=00 -> rsp_d=8, ovf=1.
   - a=0, op=11, cin=0 -> rsp_d=15, cout=0.
4. Backpressure: hold rsp_ready=0 for 10 cycles. Required: rsp_* stable, req_ready=0, and a req_valid pulse during that time is ignored. Release rsp_ready: IDLE on the next edge, req_ready=1.
5. Mismatch injection: the bench drives au_d=4'b0101 for a=2, b=2, op=00 -> rsp_d=5, rsp_mismatch=1.
6. Reset in SETTLE: assert rst one cycle after acceptance. Next cycle: state IDLE, rsp_valid=0, au_*=0. A following request a=1, b=1, op=00 completes normally with rsp_d=2.

Source files
------------

// File: rtl/arith_seq_pkg.sv
// Shared types and constants for the add/sub unit sequencer.
package arith_seq_pkg;

    localparam int DEFAULT_WIDTH         = 4;
    localparam int DEFAULT_SETTLE_CYCLES = 3;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_INC  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        RESP   = 2'b10
    } state_t;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic ovf_of(input logic a_msb, input logic y_msb, input logic d_msb);
        return (a_msb == y_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/arith_ref_model.sv
// Combinational reference for the add/sub unit: d = a + y + cin, y picked by op.
import arith_seq_pkg::*;

module arith_ref_model #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             y_msb,
    output logic [WIDTH-1:0] d,
    output logic             cout
);

    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   sum;

    // Select the second operand, then add at WIDTH+1 bits so the carry is kept.
    always_comb begin
        y = b;
        unique case (op)
            OP_ADD:  y = b;
            OP_SUB:  y = ~b;
            OP_PASS: y = '0;
            OP_INC:  y = '1;
            default: y = b;
        endcase
        sum   = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        y_msb = y[WIDTH-1];
        d     = sum[WIDTH-1:0];
        cout  = sum[WIDTH];
    end

endmodule

// File: rtl/arith_op_sequencer.sv
// Drives the add/sub unit from registers, waits for the ripple to settle,
// captures the result and hands it back with flags and a self-check bit.
//
// state  | meaning
// IDLE   | ready for a request; au_* hold the last operands
// SETTLE | operands driven, counting down the ripple settle time
// RESP   | result captured and presented until the consumer takes it
import arith_seq_pkg::*;

module arith_op_sequencer #(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    input  logic             req_cin,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic [1:0]       au_s,
    output logic             au_cin,
    input  logic [WIDTH-1:0] au_d,
    input  logic             au_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_d,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_mismatch,
    output logic             busy
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;

    logic             ref_y_msb;
    logic [WIDTH-1:0] ref_d;
    logic             ref_cout;

    // Reference runs off the registered operands so it sees exactly what the unit sees.
    arith_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a     (au_a),
        .b     (au_b),
        .op    (au_s),
        .cin   (au_cin),
        .y_msb (ref_y_msb),
        .d     (ref_d),
        .cout  (ref_cout)
    );

    // Handshake status is a pure decode of the state register.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Sequencer FSM with all operand and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            au_a         <= '0;
            au_b         <= '0;
            au_s         <= '0;
            au_cin       <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_d        <= '0;
            rsp_cout     <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_ovf      <= 1'b0;
            rsp_mismatch <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        au_a       <= req_a;
                        au_b       <= req_b;
                        au_s       <= req_op;
                        au_cin     <= req_cin;
                        settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        rsp_d        <= au_d;
                        rsp_cout     <= au_cout;
                        rsp_zero     <= (au_d == '0);
                        rsp_ovf      <= ovf_of(au_a[WIDTH-1], ref_y_msb, au_d[WIDTH-1]);
                        rsp_mismatch <= ({au_cout, au_d} != {ref_cout, ref_d});
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Scoreboard bench for arith_op_sequencer with a behavioural add/sub unit attached.
module tb_arith_op_sequencer;
    import arith_seq_pkg::*;

    localparam int W      = 4;
    localparam int SETTLE = 3;

    typedef struct packed {
        logic [W-1:0] d;
        logic         cout;
        logic         zero;
        logic         ovf;
        logic         mism;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [1:0]   req_op = '0;
    logic         req_cin = 1'b0;
    logic [W-1:0] au_a, au_b;
    logic [1:0]   au_s;
    logic         au_cin;
    logic [W-1:0] au_d;
    logic         au_cout;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_d;
    logic         rsp_cout, rsp_zero, rsp_ovf, rsp_mismatch, busy;

    logic         inj_en = 1'b0;
    logic [W-1:0] inj_d  = '0;
    logic [W-1:0] unit_y;
    logic [W:0]   unit_sum;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Behavioural add/sub unit, with an override on d for fault injection.
    always_comb begin
        unit_y = au_b;
        case (au_s)
            2'b00:   unit_y = au_b;
            2'b01:   unit_y = ~au_b;
            2'b10:   unit_y = '0;
            default: unit_y = '1;
        endcase
        unit_sum = {1'b0, au_a} + {1'b0, unit_y} + {{W{1'b0}}, au_cin};
        au_d     = inj_en ? inj_d : unit_sum[W-1:0];
        au_cout  = unit_sum[W];
    end

    arith_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .req_cin      (req_cin),
        .au_a         (au_a),
        .au_b         (au_b),
        .au_s         (au_s),
        .au_cin       (au_cin),
        .au_d         (au_d),
        .au_cout      (au_cout),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_d        (rsp_d),
        .rsp_cout     (rsp_cout),
        .rsp_zero     (rsp_zero),
        .rsp_ovf      (rsp_ovf),
        .rsp_mismatch (rsp_mismatch),
        .busy         (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed response handshake is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rsp_d",        int'(rsp_d),        int'(e.d));
                check("rsp_cout",     int'(rsp_cout),     int'(e.cout));
                check("rsp_zero",     int'(rsp_zero),     int'(e.zero));
                check("rsp_ovf",      int'(rsp_ovf),      int'(e.ovf));
                check("rsp_mismatch", int'(rsp_mismatch), int'(e.mism));
            end
        end
    end

    // Called at #1 after a posedge with the DUT idle; leaves the caller at #1 after a posedge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input logic cin, input exp_t e);
        int n;
        sb.push_back(e);
        req_a = a; req_b = b; req_op = op; req_cin = cin; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("au_a", int'(au_a), int'(a));
        check("au_b", int'(au_b), int'(b));
        check("au_s", int'(au_s), int'(op));
        check("au_cin", int'(au_cin), int'(cin));
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_valid) check("rsp_timeout", 0, 1);
        else            check("latency", n, SETTLE);
        if (rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_au", int'({au_a, au_b, au_s, au_cin}), 0);
        check("rst_rsp", int'({rsp_d, rsp_cout, rsp_zero, rsp_ovf, rsp_mismatch}), 0);
        @(posedge clk); #1;

        // d, cout, zero, ovf, mismatch
        do_op(4'd3,  4'd3, OP_ADD, 1'b0, '{4'd6,  1'b0, 1'b0, 1'b0, 1'b0});
        do_op(4'd5,  4'd3, OP_SUB, 1'b1, '{4'd2,  1'b1, 1'b0, 1'b0, 1'b0});
        do_op(4'd3,  4'd5, OP_SUB, 1'b1, '{4'd14, 1'b0, 1'b0, 1'b0, 1'b0});
        do_op(4'd15, 4'd1, OP_ADD, 1'b0, '{4'd0,  1'b1, 1'b1, 1'b0, 1'b0});
        do_op(4'd7,  4'd1, OP_ADD, 1'b0, '{4'd8,  1'b0, 1'b0, 1'b1, 1'b0});
        do_op(4'd0,  4'd0, OP_INC, 1'b0, '{4'd15, 1'b0, 1'b0, 1'b0, 1'b0});
        do_op(4'd9,  4'd7, OP_PASS, 1'b1, '{4'd10, 1'b0, 1'b0, 1'b0, 1'b0});

        // Backpressure: response held, stray request ignored.
        rsp_ready = 1'b0;
        do_op(4'd9, 4'd4, OP_ADD, 1'b1, '{4'd14, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                req_a = 4'd1; req_b = 4'd1; req_op = OP_ADD; req_cin = 1'b0; req_valid = 1'b1;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("bp_rsp_valid", int'(rsp_valid), 1);
            check("bp_rsp_d", int'(rsp_d), 14);
            check("bp_req_ready", int'(req_ready), 0);
        end
        check("bp_au_a_held", int'(au_a), 9);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", int'(req_ready), 1);
        check("bp_release_valid", int'(rsp_valid), 0);
        check("bp_release_busy", int'(busy), 0);
        repeat (6) @(posedge clk);
        #1;

        // Unit returns a wrong sum; it must be reported as-is with mismatch set.
        inj_en = 1'b1; inj_d = 4'b0101;
        do_op(4'd2, 4'd2, OP_ADD, 1'b0, '{4'd5, 1'b0, 1'b0, 1'b0, 1'b1});
        inj_en = 1'b0;

        // Reset one cycle after acceptance discards the operation.
        req_a = 4'd6; req_b = 4'd6; req_op = OP_ADD; req_cin = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(req_ready), 1);
        check("mid_rst_rsp_valid", int'(rsp_valid), 0);
        check("mid_rst_au", int'({au_a, au_b, au_s, au_cin}), 0);
        do_op(4'd1, 4'd1, OP_ADD, 1'b0, '{4'd2, 1'b0, 1'b0, 1'b0, 1'b0});

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
